// File: rtl/ofifo_col_bank_pkg.sv
// Shared project parameters for the systolic array datapath (mac_tile,
// mac array and output FIFO bank) plus a small pointer-width helper.
package ofifo_col_bank_pkg;

  localparam int unsigned COL     = 8;   // array columns
  localparam int unsigned PSUM_BW = 16;  // partial-sum width per column
  localparam int unsigned DEPTH   = 16;  // default entries per column FIFO

  // Pointer width: one extra MSB beyond the address so that full and
  // empty can be told apart when the low bits match.
  function automatic int unsigned ptr_bits(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/fifo_col.sv
// Single-column synchronous FIFO.
//   clk     : clock, all state changes on rising edge
//   reset   : synchronous active-high, clears both pointers
//   wr      : write request; taken when not full, or when rd pops this cycle
//   rd      : pop (already qualified by the bank: only asserted when non-empty)
//   in      : write data
//   out     : current head entry (combinational from storage)
//   o_full  : depth entries stored
//   o_empty : no entries stored
module fifo_col
  import ofifo_col_bank_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] in,
  output logic [psum_bw-1:0] out,
  output logic               o_full,
  output logic               o_empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = ptr_bits(depth);

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [psum_bw-1:0] mem [depth];
  logic               wr_en;

  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // When full, a same-cycle pop frees the slot being written; the head is
  // captured by the bank on the same edge, so the overwrite is safe.
  assign wr_en = wr && (!o_full || rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd)    rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wptr[AW-1:0]] <= in;
  end

  assign out = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ofifo_col_bank.sv
// Output FIFO bank: one FIFO per array column, drained as aligned rows.
//   clk        : clock
//   reset      : synchronous active-high; clears pointers, out, overflow
//   in         : column psums, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//   wr         : per-column write strobe
//   rd         : pop one aligned row (ignored unless o_valid)
//   out        : registered row, loaded on an accepted pop
//   o_valid    : every column non-empty
//   o_full     : at least one column full
//   o_ready    : ~o_full
//   o_overflow : sticky, set when a write was dropped
module ofifo_col_bank
  import ofifo_col_bank_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [col-1:0]         full;
  logic [col-1:0]         empty;
  logic [col*psum_bw-1:0] heads;
  logic                   pop;
  logic                   drop;

  for (genvar g = 0; g < col; g++) begin : g_col
    fifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[g]),
      .rd      (pop),
      .in      (in[psum_bw*g +: psum_bw]),
      .out     (heads[psum_bw*g +: psum_bw]),
      .o_full  (full[g]),
      .o_empty (empty[g])
    );
  end

  // Flags come from pointer state only; a write into an empty column is
  // never bypassed to the same-cycle pop.
  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;

  assign pop  = rd && o_valid;
  assign drop = |(wr & full) && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop)  out        <= heads;
      if (drop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo_col_bank.sv
module tb_ofifo_col_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_bus;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         o_full;
  logic         o_ready;
  logic         o_overflow;

  int total = 0;
  int bad   = 0;

  ofifo_col_bank #(
    .col     (8),
    .psum_bw (16),
    .depth   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_bus),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Column i = base + i*stp
  function automatic logic [127:0] row(input logic [15:0] base, input logic [15:0] stp);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = base + 16'(i) * stp;
    return r;
  endfunction

  logic [127:0] exp_row;
  logic [127:0] held;

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in_bus = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_ovf", o_overflow, 0);

    // Basic row, written with a concurrent rd while empty (no bypass)
    in_bus = row(16'd1, 16'd1); wr = 8'hFF; rd = 1'b1;
    step();
    wr = '0; rd = 1'b0;
    chk("nobypass_out", out, 0);
    chk("basic_valid", o_valid, 1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("basic_out", out, row(16'd1, 16'd1));
    chk("basic_valid_after", o_valid, 0);

    // Skewed fill
    for (int i = 0; i < 8; i++) begin
      in_bus = '0;
      in_bus[16*i +: 16] = 16'h0100 + 16'(i);
      wr = 8'(1 << i);
      step();
      chk($sformatf("skew_valid%0d", i), o_valid, (i == 7) ? 1 : 0);
    end
    wr = '0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("skew_out", out, row(16'h0100, 16'd1));
    chk("skew_valid_after", o_valid, 0);

    // rd while empty is ignored
    held = out;
    rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("empty_rd_out%0d", c), out, held);
      chk($sformatf("empty_rd_valid%0d", c), o_valid, 0);
    end
    rd = 1'b0;

    // Fill column 3 alone, then overflow it
    wr = 8'b0000_1000;
    for (int k = 0; k < 16; k++) begin
      in_bus = '0;
      in_bus[48 +: 16] = 16'h3000 + 16'(k);
      step();
    end
    chk("col3_full", o_full, 1);
    chk("col3_ready", o_ready, 0);
    chk("col3_ovf_pre", o_overflow, 0);
    in_bus[48 +: 16] = 16'h3FFF;
    step();
    wr = '0;
    chk("col3_ovf", o_overflow, 1);
    chk("col3_full_still", o_full, 1);
    in_bus = row(16'h00A0, 16'd0); wr = 8'b1111_0111;
    step();
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    exp_row = row(16'h00A0, 16'd0);
    exp_row[48 +: 16] = 16'h3000;
    chk("col3_pop_out", out, exp_row);
    chk("col3_ovf_sticky", o_overflow, 1);
    chk("col3_full_after_pop", o_full, 0);

    // Reset clears everything
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_ovf", o_overflow, 0);
    chk("rst2_valid", o_valid, 0);
    chk("rst2_out", out, 0);

    // All columns full, pop and write in the same cycle
    wr = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      in_bus = row(16'(k), 16'h0100);
      step();
    end
    wr = '0;
    chk("allfull_full", o_full, 1);
    chk("allfull_valid", o_valid, 1);
    in_bus = row(16'hBEEF, 16'd0); wr = 8'hFF; rd = 1'b1;
    step();
    wr = '0;
    chk("concur_out", out, row(16'd0, 16'h0100));
    chk("concur_ovf", o_overflow, 0);
    chk("concur_full", o_full, 1);
    for (int k = 1; k < 17; k++) begin
      step();
      chk($sformatf("drain_out%0d", k), out,
          (k == 16) ? row(16'hBEEF, 16'd0) : row(16'(k), 16'h0100));
    end
    rd = 1'b0;
    chk("drain_valid", o_valid, 0);

    // Stream 20 rows to wrap the pointers
    for (int r = 0; r < 20; r++) begin
      in_bus = row(16'h2000 + 16'(r), 16'h0100); wr = 8'hFF;
      step();
      wr = '0; rd = 1'b1;
      step();
      rd = 1'b0;
      chk($sformatf("stream_out%0d", r), out, row(16'h2000 + 16'(r), 16'h0100));
    end

    // Reset mid-stream with entries pending
    in_bus = row(16'h4400, 16'd1); wr = 8'hFF;
    step();
    in_bus = row(16'h4500, 16'd1);
    step();
    wr = '0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_ovf", o_overflow, 0);
    in_bus = row(16'h5500, 16'd1); wr = 8'hFF;
    step();
    in_bus = row(16'h5600, 16'd1);
    step();
    wr = '0; rd = 1'b1;
    step();
    chk("post_rst_out0", out, row(16'h5500, 16'd1));
    step();
    rd = 1'b0;
    chk("post_rst_out1", out, row(16'h5600, 16'd1));
    chk("post_rst_valid", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofifo_col_bank.md
OFIFO_COL_BANK -- requirements
Module: ofifo_col_bank

Interface
REQ-001 SHALL have parameter col, default 8, meaning number of array columns drained.
REQ-002 SHALL have parameter psum_bw, default 16, meaning partial-sum width per column.
REQ-003 SHALL have parameter depth, default 16, meaning entries per column FIFO (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in, input, col*psum_bw, psums from the array's out_s; column i at bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 SHALL have port wr, input, col, per-column write strobe (column valid from the array bottom).
REQ-008 SHALL have port rd, input, 1, request to pop one aligned row (one entry from every column).
REQ-009 SHALL have port out, output, col*psum_bw, registered aligned row, same bit layout as in.
REQ-010 SHALL have port o_valid, output, 1, every column FIFO non-empty.
REQ-011 SHALL have port o_full, output, 1, at least one column FIFO full.
REQ-012 SHALL have port o_ready, output, 1, equals ~o_full.
REQ-013 SHALL have port o_overflow, output, 1, sticky flag: a write was dropped.

Function
REQ-014 Each column SHALL be an independent FIFO with read/write pointers of log2(depth)+1 bits; empty when pointers equal, full when low bits equal and MSBs differ; pointers wrap naturally.
REQ-015 A write on column i SHALL be accepted when wr[i]=1 and (column i not full or a row pop is accepted in the same cycle); accepted data visible at head from the next cycle.
REQ-016 A write to a full column with no same-cycle pop SHALL be dropped, pointers unchanged, o_overflow set to 1 next cycle and held until reset.
REQ-017 A row pop SHALL be accepted only when rd=1 and o_valid=1; it advances every column's read pointer by one.
REQ-018 rd while o_valid=0 SHALL be ignored: no pointer change, out unchanged, no error flag.
REQ-019 On accepted pop, out SHALL load the concatenated column heads on that edge (1-cycle latency from rd to data on out); otherwise out holds its value.
REQ-020 o_valid, o_full, o_ready SHALL be combinational from the pointer registers only (no dependence on wr/rd in the same cycle).
REQ-021 Write into an empty column concurrent with rd SHALL not be bypassed: o_valid rises the cycle after the write at earliest.
REQ-022 Columns SHALL accept skewed writes (column i arriving i cycles after column 0) without loss as long as no column exceeds depth entries.
REQ-023 No arithmetic on data; psums SHALL pass bit-exact.

Reset
REQ-024 While reset=1, all pointers, out, and o_overflow SHALL clear to 0 on the clock edge; wr and rd ignored.
REQ-025 After reset, o_valid=0, o_full=0, o_ready=1, out=0; reset mid-operation SHALL discard all stored entries.

Structure
REQ-026 Parameters col, psum_bw and the default depth SHALL live in the shared project parameter package, common with the mac array and mac_tile.
REQ-027 One sub-module SHALL be used: fifo_col (single-column synchronous FIFO, parameters psum_bw and depth, ports clk, reset, wr, rd, in, out, o_full, o_empty), instantiated col times via generate.
REQ-028 Top level SHALL hold only the rd-accept logic, output register, flags and overflow register.

Verification
REQ-029 Reset, then wr=8'hFF for 1 cycle with column i = i+1 -> o_valid=1 next cycle; rd=1 -> following cycle out column i = i+1, o_valid=0.
REQ-030 Skewed fill: column i written with value 16'h0100+i at cycle i, i=0..7 -> o_valid stays 0 until cycle after column 7 write, then 1; pop returns all eight values aligned.
REQ-031 Fill column 3 with 16 entries (others empty) -> o_full=1, o_ready=0; 17th write dropped, o_overflow=1 and stays 1 after later pops.
REQ-032 All columns full, rd=1 and wr=8'hFF with value 16'hBEEF same cycle -> pop accepted, writes accepted, o_overflow=0, occupancy stays 16.
REQ-033 rd=1 with all columns empty for 5 cycles -> out unchanged, pointers unchanged, o_valid=0.
REQ-034 Write 20 rows through (pop each after write) to wrap pointers, then assert reset mid-stream -> next cycle o_valid=0, out=0, o_overflow=0; subsequent data correct in order.
